shared_dp_sched: RTL and testbench

//  Multi-cycle scheduled implementation of the signed dataflow d=a+b, e=a+c, g=(d>e), z=g?d:e,
//  f=a*c, x=f-d. One shared add/sub ALU and one pipelined multiplier are sequenced by an FSM.
//  It replaces the fully-parallel combinational form where area matters. Start/done handshake.

---
 rtl/shared_dp_sched.sv | 173 +++++++++++++++++
 tb/tb_shared_dp_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_dp_sched.sv
// Scheduled datapath: d=a+b, e=a+c, z=(d>e)?d:e, x=a*c-d on one shared add/sub ALU
// plus a local multiplier pipeline, sequenced by a start/done FSM.
module shared_dp_sched #(
  parameter int DATAW   = 8,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAW-1:0]     a,
  input  logic [DATAW-1:0]     b,
  input  logic [DATAW-1:0]     c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAW-1:0]     z,
  output logic [2*DATAW-1:0]   x
);

  localparam int XW = 2 * DATAW;
  localparam int W  = (MUL_LAT > 2) ? (MUL_LAT - 2) : 1;
  localparam logic [3:0] W_INIT = 4'(W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD1 = 3'd1;
  localparam logic [2:0] S_ADD2 = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_MULW = 3'd4;
  localparam logic [2:0] S_SUB  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  function automatic logic [XW-1:0] sext(input logic [DATAW-1:0] v);
    return {{DATAW{v[DATAW-1]}}, v};
  endfunction

  logic [2:0]       state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [DATAW-1:0] a_reg, b_reg, c_reg;
  logic [DATAW-1:0] d_reg, d_next;
  logic [DATAW-1:0] e_reg, e_next;
  logic [DATAW-1:0] z_reg, z_next;
  logic [XW-1:0]    x_reg, x_next;
  logic [XW-1:0]    f_reg;
  logic             accept;
  logic             launch;

  // Shared ALU: operands and add/sub selection are steered by the current state.
  logic [XW-1:0] alu_a, alu_b, alu_res;
  logic          alu_sub;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    case (state_reg)
      S_ADD1: begin
        alu_a = sext(a_reg);
        alu_b = sext(b_reg);
      end
      S_ADD2: begin
        alu_a = sext(a_reg);
        alu_b = sext(c_reg);
      end
      S_CMP: begin
        // e-d at double width cannot overflow, so its sign bit is exactly (d > e).
        alu_a   = sext(e_reg);
        alu_b   = sext(d_reg);
        alu_sub = 1'b1;
      end
      S_SUB: begin
        alu_a   = f_reg;
        alu_b   = sext(d_reg);
        alu_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

  assign accept = (state_reg == S_IDLE) && start;
  assign launch = (state_reg == S_ADD1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    e_next     = e_reg;
    z_next     = z_reg;
    x_next     = x_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_ADD1;
      S_ADD1: begin
        d_next     = alu_res[DATAW-1:0];
        cnt_next   = W_INIT;
        state_next = S_ADD2;
      end
      S_ADD2: begin
        e_next     = alu_res[DATAW-1:0];
        state_next = S_CMP;
      end
      S_CMP: begin
        z_next     = alu_res[XW-1] ? d_reg : e_reg;
        state_next = S_MULW;
      end
      S_MULW: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = S_SUB;
      end
      S_SUB: begin
        x_next     = alu_res;
        state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      e_reg     <= '0;
      z_reg     <= '0;
      x_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      e_reg     <= e_next;
      z_reg     <= z_next;
      x_reg     <= x_next;
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        c_reg <= c;
      end
    end
  end

  // Multiplier pipeline advances every cycle; a valid token tracks the launched product
  // so the result is parked in f_reg regardless of how long the FSM waits afterwards.
  logic [XW-1:0]      prod;
  logic [XW-1:0]      mul_pipe [MUL_LAT];
  logic [MUL_LAT-1:0] mul_vld;

  assign prod = sext(a_reg) * sext(c_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
      mul_vld <= '0;
      f_reg   <= '0;
    end else begin
      mul_pipe[0] <= prod;
      mul_vld[0]  <= launch;
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_pipe[i] <= mul_pipe[i-1];
        mul_vld[i]  <= mul_vld[i-1];
      end
      if (mul_vld[MUL_LAT-1]) f_reg <= mul_pipe[MUL_LAT-1];
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);
  assign z    = z_reg;
  assign x    = x_reg;

endmodule

// File: tb/tb_shared_dp_sched.sv
// Directed bench for shared_dp_sched: one DUT with MUL_LAT=2 and one with MUL_LAT=5.
module tb_shared_dp_sched;

  logic        clk;
  logic        rst;
  logic        start, start5;
  logic [7:0]  a, b, c, a5, b5, c5;
  logic        busy, done, busy5, done5;
  logic [7:0]  z, z5;
  logic [15:0] x, x5;

  int total = 0;
  int bad   = 0;

  shared_dp_sched #(.DATAW(8), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .z(z), .x(x)
  );

  shared_dp_sched #(.DATAW(8), .MUL_LAT(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .c(c5),
    .busy(busy5), .done(done5), .z(z5), .x(x5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [7:0] ia, ib, ic,
                                output logic [7:0] mz, output logic [15:0] mx);
    int sa, sb, sc, d, e;
    logic [7:0] d8, e8;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    sc = int'($signed(ic));
    d8 = 8'(sa + sb);
    e8 = 8'(sa + sc);
    d  = int'($signed(d8));
    e  = int'($signed(e8));
    mz = (d > e) ? d8 : e8;
    mx = 16'(sa * sc - d);
  endfunction

  // Drives one op (accept edge = cycle 0) and records what happens in cycles 1..20.
  task automatic run_op(input bit sel, input logic [7:0] ia, ib, ic,
                        output int done_cyc, output int n_done,
                        output int busy_lo, output int busy_hi,
                        output logic [7:0] oz, output logic [15:0] ox);
    done_cyc = -1; n_done = 0; busy_lo = -1; busy_hi = -1; oz = '0; ox = '0;
    @(negedge clk);
    if (sel) begin start5 = 1'b1; a5 = ia; b5 = ib; c5 = ic; end
    else     begin start  = 1'b1; a  = ia; b  = ib; c  = ic; end
    @(negedge clk);
    start = 1'b0; start5 = 1'b0;
    a  = 8'($urandom); b  = 8'($urandom); c  = 8'($urandom);
    a5 = 8'($urandom); b5 = 8'($urandom); c5 = 8'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (sel ? busy5 : busy) begin
        if (busy_lo < 0) busy_lo = k;
        busy_hi = k;
      end
      if (sel ? done5 : done) begin
        n_done++;
        done_cyc = k;
        oz = sel ? z5 : z;
        ox = sel ? x5 : x;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (z !== 8'h00) begin bad++; $display("FAIL reset_z: got %h want 00", z); end
    total++; if (x !== 16'h0000) begin bad++; $display("FAIL reset_x: got %h want 0000", x); end
    total++; if (busy5 !== 1'b0 || z5 !== 8'h00 || x5 !== 16'h0000) begin
      bad++; $display("FAIL reset_dut5: busy=%b z=%h x=%h want 0/00/0000", busy5, z5, x5);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || z !== 8'h00 || x !== 16'h0000) begin
        bad++;
        $display("FAIL idle_hold: cycle %0d busy=%b done=%b z=%h x=%h want 0/0/00/0000", k, busy, done, z, x);
      end
    end
    $display("test_reset: checked reset values and 20 idle cycles");
  endtask

  task automatic test_basic();
    int dc, nd, bl, bh;
    logic [7:0] oz;
    logic [15:0] ox;
    run_op(1'b0, 8'd3, 8'd4, 8'd2, dc, nd, bl, bh, oz, ox);
    total++; if (dc !== 6) begin bad++; $display("FAIL basic_done_cycle: got %0d want 6", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    total++; if (bl !== 1 || bh !== 6) begin bad++; $display("FAIL basic_busy_window: got %0d..%0d want 1..6", bl, bh); end
    total++; if (oz !== 8'd7) begin bad++; $display("FAIL basic_z: got %h want 07", oz); end
    total++; if (ox !== 16'hFFFF) begin bad++; $display("FAIL basic_x: got %h want ffff", ox); end
    $display("test_basic: a=3 b=4 c=2 -> z=%h x=%h done@%0d", oz, ox, dc);
  endtask

  task automatic test_wrap();
    int dc, nd, bl, bh;
    logic [7:0] oz;
    logic [15:0] ox;
    run_op(1'b0, 8'd100, 8'd100, 8'h9C, dc, nd, bl, bh, oz, ox);
    total++; if (oz !== 8'h00) begin bad++; $display("FAIL wrap_z: got %h want 00", oz); end
    total++; if (ox !== 16'hD928) begin bad++; $display("FAIL wrap_x: got %h want d928", ox); end
    total++; if (dc !== 6 || nd !== 1) begin bad++; $display("FAIL wrap_done: got cycle %0d count %0d want 6/1", dc, nd); end
    $display("test_wrap: a=100 b=100 c=-100 -> z=%h x=%h", oz, ox);
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa [0:31];
    logic [7:0] qb [0:31];
    logic [7:0] qc [0:31];
    logic [7:0] mz;
    logic [15:0] mx;
    int ndone, cyc, k;
    bit exp_done, exp_busy;
    ndone = 0;
    @(negedge clk);
    for (int n = 0; n < 28; n++) begin
      qa[n] = 8'(n * 37 + 5);
      qb[n] = 8'(n * 11 - 3);
      qc[n] = 8'(100 - n * 13);
      a = qa[n]; b = qb[n]; c = qc[n]; start = 1'b1;
      @(negedge clk);
      cyc = n + 1;
      exp_done = ((cyc % 7) == 6);
      exp_busy = ((cyc % 7) != 0);
      total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done: cycle %0d got %b want %b", cyc, done, exp_done); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL b2b_busy: cycle %0d got %b want %b", cyc, busy, exp_busy); end
      if (exp_done) begin
        ndone++;
        k = cyc - 6;
        model(qa[k], qb[k], qc[k], mz, mx);
        total++; if (z !== mz) begin bad++; $display("FAIL b2b_z: op@%0d got %h want %h", k, z, mz); end
        total++; if (x !== mx) begin bad++; $display("FAIL b2b_x: op@%0d got %h want %h", k, x, mx); end
        $display("test_back_to_back: op accepted at %0d a=%h b=%h c=%h -> z=%h x=%h", k, qa[k], qb[k], qc[k], z, x);
      end
    end
    start = 1'b0;
    total++; if (ndone != 4) begin bad++; $display("FAIL b2b_ops: got %0d want 4", ndone); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int dc, nd, bl, bh, seen;
    logic [7:0] oz;
    logic [15:0] ox;
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd4; c = 8'd2;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55; c = 8'h77;
    repeat (3) @(negedge clk);
    total++; if (z !== 8'd7) begin bad++; $display("FAIL mid_z_before_sub: got %h want 07", z); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl: busy=%b done=%b want 0/0", busy, done); end
    total++; if (z !== 8'h00 || x !== 16'h0000) begin bad++; $display("FAIL mid_rst_out: z=%h x=%h want 00/0000", z, x); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_quiet: got %0d active cycles want 0", seen); end
    run_op(1'b0, 8'hFB, 8'd9, 8'd7, dc, nd, bl, bh, oz, ox);
    total++; if (oz !== 8'd4 || ox !== 16'hFFD9) begin bad++; $display("FAIL mid_rst_next_op: z=%h x=%h want 04/ffd9", oz, ox); end
    total++; if (dc !== 6 || nd !== 1) begin bad++; $display("FAIL mid_rst_next_done: cycle %0d count %0d want 6/1", dc, nd); end
    $display("test_reset_mid: after reset a=-5 b=9 c=7 -> z=%h x=%h", oz, ox);
  endtask

  task automatic test_lat5();
    int dc, nd, bl, bh;
    logic [7:0] oz;
    logic [15:0] ox;
    run_op(1'b1, 8'h80, 8'h00, 8'h80, dc, nd, bl, bh, oz, ox);
    total++; if (dc !== 8 || nd !== 1) begin bad++; $display("FAIL lat5_done: cycle %0d count %0d want 8/1", dc, nd); end
    total++; if (bl !== 1 || bh !== 8) begin bad++; $display("FAIL lat5_busy_window: got %0d..%0d want 1..8", bl, bh); end
    total++; if (oz !== 8'h00) begin bad++; $display("FAIL lat5_z: got %h want 00", oz); end
    total++; if (ox !== 16'h4080) begin bad++; $display("FAIL lat5_x: got %h want 4080", ox); end
    $display("test_lat5: a=-128 b=0 c=-128 -> z=%h x=%h done@%0d", oz, ox, dc);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; start5 = 1'b0;
    a = '0; b = '0; c = '0; a5 = '0; b5 = '0; c5 = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_lat5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
